// File: rtl/lp_pkg.sv
// lp_pkg: types and defaults shared by the lp lowpass stage and its
// downstream blocks.
//   DATA_W       default sample width (two's complement)
//   N_CH / CH_W  default channel count and channel-index width
//   lp_sample_t  one interleaved sample beat as emitted by lp
//   skid_state_e occupancy of the two-entry skid buffer
package lp_pkg;

  localparam int DATA_W = 24;
  localparam int N_CH   = 2;
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   ch;
    logic              last;
  } lp_sample_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/lp_skid_buf.sv
// lp_skid_buf: two-entry FIFO skid buffer, generic over the beat type.
// Ready towards the producer is a register, so consumer backpressure never
// reaches the producer combinationally.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_push        write a beat (only legal while o_ready is high)
//   i_data        beat to write
//   o_ready       buffer can take a beat this cycle (not FULL)
//   o_valid       o_data holds the oldest buffered beat
//   i_ready       consumer takes o_data when o_valid is high
//   o_data        oldest buffered beat, stable until popped
module lp_skid_buf
  import lp_pkg::*;
#(
  parameter type T = lp_sample_t
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  T     i_data,
  output logic o_ready,
  output logic o_valid,
  input  logic i_ready,
  output T     o_data
);

  skid_state_e state, state_nxt;
  T            ent_p1;
  logic        pop;

  assign o_valid = (state != SKID_EMPTY);
  assign pop     = o_valid && i_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      SKID_EMPTY: if (i_push) state_nxt = SKID_ONE;
      SKID_ONE: begin
        if (i_push && !pop)      state_nxt = SKID_FULL;
        else if (pop && !i_push) state_nxt = SKID_EMPTY;
      end
      SKID_FULL: if (pop) state_nxt = SKID_ONE;
      default:   state_nxt = SKID_EMPTY;
    endcase
  end

  // Stage p0: o_data is the head entry, ent_p1 the younger entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= SKID_EMPTY;
      o_ready <= 1'b0;
      o_data  <= '0;
      ent_p1  <= '0;
    end else begin
      state   <= state_nxt;
      o_ready <= (state_nxt != SKID_FULL);
      unique case (state)
        SKID_EMPTY: if (i_push) o_data <= i_data;
        SKID_ONE: begin
          // Push with pop streams straight into the head; push alone parks
          // the beat behind the head.
          if (i_push && pop) o_data <= i_data;
          else if (i_push)   ent_p1 <= i_data;
        end
        SKID_FULL: if (pop) o_data <= ent_p1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lp_decim.sv
// lp_decim: frame-synchronous decimator downstream of lp. Forwards every beat
// of one frame out of each r_decim frames and drops the rest; kept beats pass
// through a two-entry skid buffer.
// Ports:
//   i_clk, i_rst                          clock, synchronous active-high reset
//   i_s_valid/o_s_ready                   upstream handshake
//   i_s_data/i_s_ch/i_s_last              upstream sample, channel, frame end
//   i_decim                               requested ratio (0->1, >MAX clamps)
//   o_m_valid/i_m_ready                   downstream handshake
//   o_m_data/o_m_ch/o_m_last              forwarded sample, channel, frame end
//   o_err                                 sticky framing error
module lp_decim #(
  parameter  int DATA_W    = lp_pkg::DATA_W,
  parameter  int N_CH      = 2,
  parameter  int MAX_DECIM = 16,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int DECIM_W   = $clog2(MAX_DECIM + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_s_valid,
  output logic                o_s_ready,
  input  logic [DATA_W-1:0]   i_s_data,
  input  logic [CH_W-1:0]     i_s_ch,
  input  logic                i_s_last,
  input  logic [DECIM_W-1:0]  i_decim,
  output logic                o_m_valid,
  input  logic                i_m_ready,
  output logic [DATA_W-1:0]   o_m_data,
  output logic [CH_W-1:0]     o_m_ch,
  output logic                o_m_last,
  output logic                o_err
);

  import lp_pkg::*;

  // Same layout as lp_sample_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   ch;
    logic              last;
  } sample_t;

  localparam logic [CH_W-1:0]    LAST_CH = CH_W'(N_CH - 1);
  localparam logic [DECIM_W-1:0] ONE_D   = DECIM_W'(1);
  localparam logic [DECIM_W-1:0] MAX_D   = DECIM_W'(MAX_DECIM);

  function automatic logic [DECIM_W-1:0] sanitize(input logic [DECIM_W-1:0] d);
    if (d == '0)         return ONE_D;
    else if (d > MAX_D)  return MAX_D;
    else                 return d;
  endfunction

  logic [DECIM_W-1:0] phase;
  logic [DECIM_W-1:0] r_decim;
  logic               accept;
  logic               keep;
  logic               frame_bad;
  sample_t            s_beat;
  sample_t            m_beat;

  assign accept    = i_s_valid && o_s_ready;
  assign keep      = (phase == '0);
  // The last flag and the channel index must agree on where the frame ends.
  assign frame_bad = i_s_last ? (i_s_ch != LAST_CH) : (i_s_ch == LAST_CH);
  assign s_beat    = '{data: i_s_data, ch: i_s_ch, last: i_s_last};

  // Stage p0: frame phase, ratio latch and framing check on accepted beats.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase   <= '0;
      r_decim <= sanitize(i_decim);
      o_err   <= 1'b0;
    end else if (accept) begin
      if (frame_bad) o_err <= 1'b1;
      if (i_s_last) begin
        // The ratio only changes at a wrap, so a frame never straddles two ratios.
        if (phase == r_decim - ONE_D) begin
          phase   <= '0;
          r_decim <= sanitize(i_decim);
        end else begin
          phase <= phase + ONE_D;
        end
      end
    end
  end

  // Stage p1: kept beats enter the skid buffer; dropped beats are simply accepted.
  lp_skid_buf #(
    .T (sample_t)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (accept && keep),
    .i_data  (s_beat),
    .o_ready (o_s_ready),
    .o_valid (o_m_valid),
    .i_ready (i_m_ready),
    .o_data  (m_beat)
  );

  assign o_m_data = m_beat.data;
  assign o_m_ch   = m_beat.ch;
  assign o_m_last = m_beat.last;

endmodule

// File: tb/tb_lp_decim.sv
// tb_lp_decim: scoreboard bench for lp_decim. Each kept beat is queued when
// driven; beats leaving the DUT are captured and compared in order.
module tb_lp_decim;

  localparam int DATA_W    = 24;
  localparam int N_CH      = 2;
  localparam int MAX_DECIM = 16;
  localparam int CH_W      = 1;
  localparam int DECIM_W   = 5;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   ch;
    logic              last;
  } exp_t;

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b1;
  logic               i_s_valid = 1'b0;
  logic               o_s_ready;
  logic [DATA_W-1:0]  i_s_data = '0;
  logic [CH_W-1:0]    i_s_ch = '0;
  logic               i_s_last = 1'b0;
  logic [DECIM_W-1:0] i_decim = 5'd1;
  logic               o_m_valid;
  logic               i_m_ready = 1'b0;
  logic [DATA_W-1:0]  o_m_data;
  logic [CH_W-1:0]    o_m_ch;
  logic               o_m_last;
  logic               o_err;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  exp_t obs_q[$];

  lp_decim #(
    .DATA_W    (DATA_W),
    .N_CH      (N_CH),
    .MAX_DECIM (MAX_DECIM)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_s_valid (i_s_valid),
    .o_s_ready (o_s_ready),
    .i_s_data  (i_s_data),
    .i_s_ch    (i_s_ch),
    .i_s_last  (i_s_last),
    .i_decim   (i_decim),
    .o_m_valid (o_m_valid),
    .i_m_ready (i_m_ready),
    .o_m_data  (o_m_data),
    .o_m_ch    (o_m_ch),
    .o_m_last  (o_m_last),
    .o_err     (o_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Capture every beat that will be popped at the coming rising edge.
  always @(negedge i_clk) begin
    if (i_rst === 1'b0 && o_m_valid === 1'b1 && i_m_ready === 1'b1)
      obs_q.push_back(exp_t'({o_m_data, o_m_ch, o_m_last}));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic [DECIM_W-1:0] d);
    i_rst     = 1'b1;
    i_decim   = d;
    i_s_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [DATA_W-1:0] d, input logic [CH_W-1:0] c,
                      input logic l, input bit keep);
    int w;
    i_s_valid = 1'b1;
    i_s_data  = d;
    i_s_ch    = c;
    i_s_last  = l;
    w = 0;
    while (o_s_ready !== 1'b1 && w < 50) begin
      @(posedge i_clk);
      #1;
      w++;
    end
    if (o_s_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL send_timeout: o_s_ready=%b, required 1", o_s_ready);
      i_s_valid = 1'b0;
      return;
    end
    if (keep) exp_q.push_back(exp_t'({d, c, l}));
    @(posedge i_clk);
    #1;
    i_s_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_m_ready = 1'b1;
    i_rst     = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    n_checks++;
    if ({o_m_valid, o_m_data, o_m_ch, o_m_last, o_err, o_s_ready} !== '0)
      $display("FAIL reset_outputs: valid=%b data=%0h ch=%0d last=%b err=%b ready=%b, required all 0",
               o_m_valid, o_m_data, o_m_ch, o_m_last, o_err, o_s_ready);
    else n_pass++;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    n_checks++;
    if (o_s_ready !== 1'b1) $display("FAIL reset_ready_rise: o_s_ready=%b, required 1", o_s_ready);
    else n_pass++;
  endtask

  task automatic test_decim4();
    exp_t e, o;
    do_reset(5'd4);
    i_m_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      send(DATA_W'(f), 1'b0, 1'b0, (f % 4) == 0);
      if (f == 0) begin
        n_checks++;
        if (o_m_valid !== 1'b1 || o_m_data !== '0)
          $display("FAIL decim4_latency: valid=%b data=%0h, required valid=1 data=0", o_m_valid, o_m_data);
        else n_pass++;
      end
      send(DATA_W'(f), 1'b1, 1'b1, (f % 4) == 0);
    end
    repeat (10) @(posedge i_clk);
    #1;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL decim4_beat: got %0h/%0d/%b, required %0h/%0d/%b",
                            o.data, o.ch, o.last, e.data, e.ch, e.last);
      else n_pass++;
    end
    n_checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0)
      $display("FAIL decim4_count: leftover expected=%0d observed=%0d, required 0/0", exp_q.size(), obs_q.size());
    else n_pass++;
  endtask

  task automatic test_decim1();
    exp_t e, o;
    int   t0;
    do_reset(5'd1);
    i_m_ready = 1'b1;
    @(posedge i_clk);
    #1;
    t0 = cyc;
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < 2; c++) begin
        send(DATA_W'(16 + 2 * f + c), CH_W'(c), c == 1, 1'b1);
        n_checks++;
        if (o_s_ready !== 1'b1) $display("FAIL decim1_ready: o_s_ready=%b, required 1", o_s_ready);
        else n_pass++;
      end
    end
    n_checks++;
    if (cyc - t0 != 8) $display("FAIL decim1_throughput: %0d cycles for 8 beats, required 8", cyc - t0);
    else n_pass++;
    repeat (10) @(posedge i_clk);
    #1;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL decim1_beat: got %0h/%0d/%b, required %0h/%0d/%b",
                            o.data, o.ch, o.last, e.data, e.ch, e.last);
      else n_pass++;
    end
    n_checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0)
      $display("FAIL decim1_count: leftover expected=%0d observed=%0d, required 0/0", exp_q.size(), obs_q.size());
    else n_pass++;
  endtask

  task automatic test_ratio_change();
    exp_t e, o;
    bit   k;
    do_reset(5'd2);
    i_m_ready = 1'b1;
    for (int f = 0; f < 10; f++) begin
      k = (f == 0) || (f == 2) || (f == 5) || (f == 8);
      send(DATA_W'(256 + f), 1'b0, 1'b0, k);
      if (f == 1) i_decim = 5'd3;
      send(DATA_W'(256 + f), 1'b1, 1'b1, k);
    end
    repeat (10) @(posedge i_clk);
    #1;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL ratio_change_beat: got %0h/%0d/%b, required %0h/%0d/%b",
                            o.data, o.ch, o.last, e.data, e.ch, e.last);
      else n_pass++;
    end
    n_checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0)
      $display("FAIL ratio_change_count: leftover expected=%0d observed=%0d, required 0/0", exp_q.size(), obs_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    exp_t e, o;
    do_reset(5'd1);
    @(posedge i_clk);
    #1;
    i_m_ready = 1'b0;
    send(24'h0000A0, 1'b0, 1'b0, 1'b1);
    send(24'h0000A1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (o_s_ready !== 1'b0 || o_m_valid !== 1'b1 || o_m_data !== 24'h0000A0 ||
          o_m_ch !== 1'b0 || o_m_last !== 1'b0)
        $display("FAIL backpressure_hold: ready=%b valid=%b data=%0h ch=%0d last=%b, required 0/1/a0/0/0",
                 o_s_ready, o_m_valid, o_m_data, o_m_ch, o_m_last);
      else n_pass++;
      @(posedge i_clk);
      #1;
    end
    i_m_ready = 1'b1;
    send(24'h0000A2, 1'b0, 1'b0, 1'b1);
    send(24'h0000A3, 1'b1, 1'b1, 1'b1);
    repeat (10) @(posedge i_clk);
    #1;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL backpressure_beat: got %0h/%0d/%b, required %0h/%0d/%b",
                            o.data, o.ch, o.last, e.data, e.ch, e.last);
      else n_pass++;
    end
    n_checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0)
      $display("FAIL backpressure_count: leftover expected=%0d observed=%0d, required 0/0", exp_q.size(), obs_q.size());
    else n_pass++;
  endtask

  task automatic test_decim0();
    exp_t e, o;
    do_reset(5'd0);
    i_m_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      send(DATA_W'(512 + f), 1'b0, 1'b0, 1'b1);
      send(DATA_W'(512 + f), 1'b1, 1'b1, 1'b1);
    end
    repeat (10) @(posedge i_clk);
    #1;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL decim0_beat: got %0h/%0d/%b, required %0h/%0d/%b",
                            o.data, o.ch, o.last, e.data, e.ch, e.last);
      else n_pass++;
    end
    n_checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0)
      $display("FAIL decim0_count: leftover expected=%0d observed=%0d, required 0/0", exp_q.size(), obs_q.size());
    else n_pass++;
  endtask

  task automatic test_decim31();
    exp_t e, o;
    do_reset(5'd31);
    i_m_ready = 1'b1;
    for (int f = 0; f < 17; f++) begin
      send(DATA_W'(768 + f), 1'b0, 1'b0, (f % 16) == 0);
      send(DATA_W'(768 + f), 1'b1, 1'b1, (f % 16) == 0);
    end
    repeat (10) @(posedge i_clk);
    #1;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL decim31_beat: got %0h/%0d/%b, required %0h/%0d/%b",
                            o.data, o.ch, o.last, e.data, e.ch, e.last);
      else n_pass++;
    end
    n_checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0)
      $display("FAIL decim31_count: leftover expected=%0d observed=%0d, required 0/0", exp_q.size(), obs_q.size());
    else n_pass++;
  endtask

  task automatic test_err_reset();
    exp_t e, o;
    do_reset(5'd1);
    @(posedge i_clk);
    #1;
    i_m_ready = 1'b0;
    n_checks++;
    if (o_err !== 1'b0) $display("FAIL err_initial: o_err=%b, required 0", o_err);
    else n_pass++;
    send(24'h0000E0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (o_err !== 1'b1) $display("FAIL err_set: o_err=%b, required 1", o_err);
    else n_pass++;
    send(24'h0000E1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (o_err !== 1'b1 || o_s_ready !== 1'b0)
      $display("FAIL err_sticky_full: o_err=%b o_s_ready=%b, required 1/0", o_err, o_s_ready);
    else n_pass++;
    i_rst   = 1'b1;
    i_decim = 5'd2;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    n_checks++;
    if ({o_m_valid, o_m_data, o_m_ch, o_m_last, o_err, o_s_ready} !== '0)
      $display("FAIL err_reset_outputs: valid=%b data=%0h ch=%0d last=%b err=%b ready=%b, required all 0",
               o_m_valid, o_m_data, o_m_ch, o_m_last, o_err, o_s_ready);
    else n_pass++;
    i_m_ready = 1'b1;
    send(24'h0000F0, 1'b0, 1'b0, 1'b1);
    send(24'h0000F1, 1'b1, 1'b1, 1'b1);
    send(24'h0000F2, 1'b0, 1'b0, 1'b0);
    send(24'h0000F3, 1'b1, 1'b1, 1'b0);
    send(24'h0000F4, 1'b0, 1'b0, 1'b1);
    send(24'h0000F5, 1'b1, 1'b1, 1'b1);
    repeat (10) @(posedge i_clk);
    #1;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL err_reset_beat: got %0h/%0d/%b, required %0h/%0d/%b",
                            o.data, o.ch, o.last, e.data, e.ch, e.last);
      else n_pass++;
    end
    n_checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0 || o_err !== 1'b0)
      $display("FAIL err_reset_count: leftover expected=%0d observed=%0d err=%b, required 0/0/0",
               exp_q.size(), obs_q.size(), o_err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_decim4();
    test_decim1();
    test_ratio_change();
    test_backpressure();
    test_decim0();
    test_decim31();
    test_err_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lp_decim.md
# lp_decim

Frame-synchronous decimator sitting directly downstream of the `lp` lowpass stage. It consumes the filtered, channel-interleaved sample stream and forwards one frame out of every `r_decim` frames, discarding the rest. Forwarded beats pass through a two-entry skid buffer, so backpressure from the consumer never creates a combinational path back to `lp`. The ratio is changeable at runtime and takes effect only on frame boundaries.

## Interface
- `DATA_W`, 24, sample width in bits (two's complement, passed through untouched).
- `N_CH`, 2, channels per frame; `CH_W = $clog2(N_CH)` (minimum 1).
- `MAX_DECIM`, 16, largest supported ratio; `DECIM_W = $clog2(MAX_DECIM+1)`.

Ports:
- `i_clk`  in  1  sole clock; all logic on its rising edge.
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_s_valid`  in  1  upstream sample valid.
- `o_s_ready`  out  1  upstream ready.
- `i_s_data`  in  DATA_W  filtered sample from `lp`.
- `i_s_ch`  in  CH_W  channel index of the sample.
- `i_s_last`  in  1  last channel of the frame.
- `i_decim`  in  DECIM_W  requested ratio; 0 is treated as 1; values above MAX_DECIM clamp to MAX_DECIM.
- `o_m_valid`  out  1  downstream valid.
- `i_m_ready`  in  1  downstream ready.
- `o_m_data`  out  DATA_W  forwarded sample.
- `o_m_ch`  out  CH_W  forwarded channel index.
- `o_m_last`  out  1  forwarded frame end.
- `o_err`  out  1  sticky framing error; cleared only by reset.

## Operation
- A beat is accepted when `i_s_valid && o_s_ready`.
- `phase` runs 0..`r_decim`-1 and counts frames.
  - All beats of the frame with `phase==0` are kept; beats of every other frame are dropped.
  - Dropped beats are still accepted but consume no buffer entry.
- On an accepted beat with `i_s_last`:
  - If `phase==r_decim-1`: set `phase<=0` and `r_decim<=sanitize(i_decim)`.
  - Otherwise: `phase<=phase+1`.
  - With `r_decim==1`, every frame is kept and the ratio is re-latched every frame.
- Ratio changes mid-frame are not seen until the next wrap. The frame in progress always completes under the old ratio.
- Framing check: `o_err` sets on an accepted beat where either
  - `i_s_last` is high and `i_s_ch != N_CH-1`, or
  - `i_s_last` is low and `i_s_ch == N_CH-1`.
  
  Data still flows, and `phase` still advances on `i_s_last`.
- The skid buffer has states EMPTY, ONE and FULL (entry count 0/1/2).
  - `o_s_ready = (state != FULL)`, decoded from registered state only.
  - push = accepted kept beat; pop = `o_m_valid && i_m_ready`.
  - EMPTY: push→ONE.
  - ONE: push&!pop→FULL; pop&!push→EMPTY; push&pop→ONE.
  - FULL: pop→ONE; push is impossible because ready is low.
- The output registers always present the oldest entry. Order is strictly FIFO.
- `o_m_data`/`o_m_ch`/`o_m_last` hold stable while `o_m_valid && !i_m_ready`.

## Timing
- Reset values:
  - Outputs: `o_m_valid=0`, `o_m_data=0`, `o_m_ch=0`, `o_m_last=0`, `o_err=0`, `o_s_ready=0`.
  - Internal state: `phase=0`; `r_decim=sanitize(i_decim)`, sampled every reset cycle.
- `o_s_ready` rises in the first cycle after `i_rst` deasserts (state EMPTY).
- Latency: a kept beat accepted in cycle n presents on `o_m_valid` in cycle n+1 if the buffer was empty.
- Throughput: one beat per cycle sustained when `i_m_ready` stays high.
- Dropped frames: `o_s_ready` stays high unless the buffer is FULL from earlier kept beats.
- Reset mid-operation: buffered beats are discarded and `phase` restarts at 0. The next frame after reset is kept.
- `o_m_valid` never deasserts without a pop; no beat is lost or duplicated.

## Structure
- Package `lp_pkg` holds:
  - the shared `DATA_W` default;
  - `typedef struct packed {logic [DATA_W-1:0] data; logic [CH_W-1:0] ch; logic last;} lp_sample_t`, also used at the `lp` output;
  - the skid state enum `skid_state_e {SKID_EMPTY, SKID_ONE, SKID_FULL}`.
- Sub-module `lp_skid_buf` is the two-entry buffer, generic over `lp_sample_t`. `lp_decim` keeps the phase/ratio logic, sanitize and the framing check.

## Test plan
- `N_CH=2`, `i_decim=4`, 8 frames with data=frame index, `i_m_ready=1` → only frames 0 and 4 are output, as ch0/ch1 pairs, with `o_m_last` on ch1; latency 1 cycle.
- `i_decim=1`, continuous valid, `i_m_ready=1` → every beat is output, ready stays high, one beat per cycle.
- `i_decim=2` set, then `i_decim=3` written during frame 1 → kept frames are 0, 2, 5, 8: the new ratio applies only after the wrap at the end of frame 1.
- Kept frame with `i_m_ready=0` for 5 cycles → buffer FULL after 2 beats, `o_s_ready=0`, output stable; releasing ready delivers both beats in order with no loss.
- `i_decim=0` and `i_decim=31` → behaves as ratio 1 and ratio 16 respectively.
- `i_s_last` on ch0, then `i_rst` pulsed mid-frame with the buffer FULL → `o_err=1` until reset; after reset all outputs are 0 and the next frame is kept.
